uart_rx: RTL and testbench

//  - UART receiver: samples async serial line UART_Tx_IN, deframes 8N1 (optional parity),

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1 framing with optional even parity.
//
// Samples the asynchronous serial line through a 2-FF synchronizer. A start
// bit is accepted once it is still low half a bit-time after its falling edge.
// The data bits (LSB first), the optional parity bit and the stop bit are then
// sampled at their bit centres. A good frame updates UART_pckt and pulses
// pckt_vld for one cycle. A low stop bit or a parity mismatch discards the word
// and sets the sticky err_ack flag.
//
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit between
// the last data bit and the stop bit.
//
// Ports:
//   r_clk       in   system clock, all logic on rising edge
//   r_rst       in   synchronous active-high reset
//   UART_Tx_IN  in   asynchronous serial line, idle high
//   err_ack     out  sticky frame/parity error flag, cleared by next good frame
//   UART_pckt   out  last good received word, LSB = first data bit
//   pckt_vld    out  one-cycle strobe when UART_pckt is updated
module uart_rx #(
    parameter int CLK_RATE    = 1_000_000,
    parameter int BAUD        = 62_500,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   r_clk,
    input  logic                   r_rst,
    input  logic                   UART_Tx_IN,
    output logic                   err_ack,
    output logic [WORD_LENGTH-1:0] UART_pckt,
    output logic                   pckt_vld
);

    localparam int BAUD_DIV = CLK_RATE / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int DCNT_W   = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [DCNT_W-1:0] BIT_LAST  = DCNT_W'(WORD_LENGTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

    state_t                 state;
    logic                   sync1;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [DCNT_W-1:0]      bit_cnt;
    logic [WORD_LENGTH-1:0] shreg;
    logic                   par_err;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err   <= 1'b0;
            err_ack   <= 1'b0;
            UART_pckt <= '0;
            pckt_vld  <= 1'b0;
        end else begin
            sync1    <= UART_Tx_IN;
            rx_s     <= sync1;
            pckt_vld <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    par_err <= 1'b0;
                    if (!rx_s) state <= START;
                end

                // Re-check the line half a bit after the falling edge so that
                // short low glitches fall back to IDLE.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[WORD_LENGTH-1:1]};
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + DCNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: the XOR of the data bits and the parity bit must be 0.
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        par_err <= (^shreg) ^ rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            // A low stop bit may be a break. Wait for the line
                            // to go high before arming for a new start bit.
                            err_ack <= 1'b1;
                            state   <= WAIT_HI;
                        end else if (par_err) begin
                            err_ack <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            UART_pckt <= shreg;
                            pckt_vld  <= 1'b1;
                            err_ack   <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WAIT_HI: begin
                    if (rx_s) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (BAUD_DIV=16, WORD_LENGTH=8).
// Drives serial frames bit by bit. Expected words, strobe counts and error
// flags come from a frame-level model of the protocol.
module tb_uart_rx;

    localparam int BD = 16;

    logic       clk;
    logic       rst;
    logic       line;
    logic       err_ack;
    logic [7:0] pckt;
    logic       vld;

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;
    logic [7:0] got_q[$];

    uart_rx #(.CLK_RATE(1_000_000), .BAUD(62_500), .WORD_LENGTH(8)) dut (
        .r_clk(clk), .r_rst(rst), .UART_Tx_IN(line),
        .err_ack(err_ack), .UART_pckt(pckt), .pckt_vld(vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with the strobe high counts, so a stretched pulse shows up
    // as an extra count.
    always @(negedge clk) begin
        if (vld) begin
            vld_cnt = vld_cnt + 1;
            got_q.push_back(pckt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        line = v;
        repeat (BD) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, [even parity], stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) begin end
`endif
        send_bit(stop);
        line = 1'b1;
    endtask

    initial begin
        int         v0;
        logic [7:0] d;
        logic [7:0] exp_word;
        logic       exp_err;
        logic       good;

        line = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pckt", pckt, 0);
        chk("rst_err", err_ack, 0);
        chk("rst_vld", vld, 0);
        rst = 1'b0;
        repeat (2 * BD) @(negedge clk);

        // Line stuck low from reset release: one error, no frame, no retrigger.
        rst  = 1'b1;
        line = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v0  = vld_cnt;
        repeat (12 * BD) @(negedge clk);
        chk("brk_err", err_ack, 1);
        chk("brk_pckt", pckt, 0);
        repeat (20 * BD) @(negedge clk);
        chk("brk_novld", vld_cnt - v0, 0);
        chk("brk_err_hold", err_ack, 1);
        line = 1'b1;
        repeat (2 * BD) @(negedge clk);

        // Basic frame 0xA5.
        v0 = vld_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_pckt", pckt, 8'hA5);
        chk("a5_vld", vld_cnt - v0, 1);
        chk("a5_err", err_ack, 0);

        // Good 0x81, then 0x3C with a low stop bit, then good 0x42.
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (BD) @(negedge clk);
        v0 = vld_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (BD) @(negedge clk);
        chk("bad_stop_err", err_ack, 1);
        chk("bad_stop_pckt", pckt, 8'h81);
        chk("bad_stop_novld", vld_cnt - v0, 0);
        send_frame(8'h42, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("x42_pckt", pckt, 8'h42);
        chk("x42_err", err_ack, 0);
        chk("x42_vld", vld_cnt - v0, 1);

        // 4-clock low glitch on the idle line.
        v0   = vld_cnt;
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (12 * BD) @(negedge clk);
        chk("glitch_novld", vld_cnt - v0, 0);
        chk("glitch_err", err_ack, 0);
        chk("glitch_pckt", pckt, 8'h42);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        v0 = vld_cnt;
        got_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("b2b_cnt", vld_cnt - v0, 2);
        chk("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h00);
        chk("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hFF);

        // Reset in the middle of the data bits of 0x55.
        v0 = vld_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        line = 1'b1;
        chk("midrst_pckt", pckt, 0);
        chk("midrst_err", err_ack, 0);
        chk("midrst_vld", vld, 0);
        repeat (2 * BD) @(negedge clk);
        chk("midrst_novld", vld_cnt - v0, 0);
        send_frame(8'h66, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("x66_pckt", pckt, 8'h66);
        chk("x66_vld", vld_cnt - v0, 1);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so a parity bit of 0 is wrong.
        v0 = vld_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par_err", err_ack, 1);
        chk("par_novld", vld_cnt - v0, 0);
        chk("par_pckt", pckt, 8'h66);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_ok_pckt", pckt, 8'h07);
        chk("par_ok_err", err_ack, 0);
`endif

        // Random frames. Model: a good frame yields exactly one strobe carrying
        // that byte and clears the error flag. A bad stop bit yields no strobe,
        // keeps the previous word and sets the flag.
        exp_word = pckt;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            v0   = vld_cnt;
            got_q.delete();
            send_frame(d, good, 1'b0);
            repeat (4) @(negedge clk);
            if (good) exp_word = d;
            exp_err = !good;
            chk("rnd_vld", vld_cnt - v0, good ? 1 : 0);
            chk("rnd_pckt", pckt, exp_word);
            chk("rnd_err", err_ack, exp_err);
            if (good) chk("rnd_strobe_word", (got_q.size() > 0) ? got_q[0] : 8'hxx, d);
            // A low stop bit needs idle time before the next start bit.
            repeat ((good ? $urandom_range(0, 2) : 1 + $urandom_range(0, 2)) * BD) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
